// File: rtl/fir_pkg.sv
// fir_pkg: shared types, defaults and width helper for the FIR convolution sequencer.
package fir_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUTPUT, DONE} state_e;

    localparam int LEN_DEF     = 19;
    localparam int SIG_LEN_DEF = 2400;
    localparam int DW_DEF      = 16;
    localparam int ACC_W_DEF   = 40;
    localparam int SHIFT_Q     = 14;
    localparam int TOTAL_DEF   = LEN_DEF + SIG_LEN_DEF + 1;

    // Address width that never collapses to zero bits for single-entry ranges.
    function automatic int aw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    localparam int COEF_AW_DEF = aw(LEN_DEF + 1);
    localparam int SIG_AW_DEF  = aw(SIG_LEN_DEF + 1);
    localparam int IDX_AW_DEF  = aw(TOTAL_DEF);

endpackage

// File: rtl/fir_mac_unit.sv
// fir_mac_unit: registered signed multiply-accumulate; first_i restarts the sum with the current product.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DW-1:0]    a_i,
    input  logic signed [DW-1:0]    b_i,
    input  logic                    en_i,
    input  logic                    first_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    assign prod = a_i * b_i;

    always_comb acc_d = !en_i ? acc_q : first_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);

    always_ff @(posedge clk or posedge rst)
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_conv_sequencer.sv
// fir_conv_sequencer: full linear convolution y = h * x on one shared MAC, one term per cycle,
// streaming one Q-scaled output per window over valid/ready.
module fir_conv_sequencer
    import fir_pkg::*;
#(
    parameter int LEN             = LEN_DEF,
    parameter int SIGNAL_LENGTH_1 = SIG_LEN_DEF,
    parameter int DW              = DW_DEF,
    parameter int ACC_W           = ACC_W_DEF,
    parameter int SHIFT           = SHIFT_Q
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      rd_en_o,
    output logic [aw(LEN+1)-1:0]                      coef_addr_o,
    output logic [aw(SIGNAL_LENGTH_1+1)-1:0]          sig_addr_o,
    input  logic signed [DW-1:0]                      coef_data_i,
    input  logic signed [DW-1:0]                      sig_data_i,
    output logic signed [DW-1:0]                      y_data_o,
    output logic [aw(LEN+SIGNAL_LENGTH_1+1)-1:0]      y_idx_o,
    output logic                                      y_valid_o,
    input  logic                                      y_ready_i
);

    localparam int TOTAL = LEN + SIGNAL_LENGTH_1 + 1;
    localparam int CW    = aw(LEN + 1);
    localparam int JW    = aw(SIGNAL_LENGTH_1 + 1);
    localparam int NW    = aw(TOTAL);

    function automatic int jlo(input int n);
        return n > LEN ? n - LEN : 0;
    endfunction

    function automatic int jhi(input int n);
        return n < SIGNAL_LENGTH_1 ? n : SIGNAL_LENGTH_1;
    endfunction

    state_e              state_q, state_d;
    logic [NW-1:0]       n_q, n_d;
    logic [JW-1:0]       j_q, j_d;
    logic                en_q, first_q;
    logic signed [ACC_W-1:0] acc;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            j_q     <= '0;
            en_q    <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            j_q     <= j_d;
            en_q    <= state_q == ISSUE;
            first_q <= state_q == ISSUE && int'(j_q) == jlo(int'(n_q));
        end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        j_d     = j_q;
        case (state_q)
            IDLE:   if (start_i) begin
                        state_d = ISSUE;
                        n_d     = '0;
                        j_d     = '0;
                    end
            ISSUE:  if (int'(j_q) == jhi(int'(n_q))) state_d = DRAIN;
                    else j_d = j_q + 1'b1;
            DRAIN:  state_d = OUTPUT;
            OUTPUT: if (y_ready_i) begin
                        if (int'(n_q) == TOTAL - 1) state_d = DONE;
                        else begin
                            state_d = ISSUE;
                            n_d     = n_q + 1'b1;
                            j_d     = JW'(jlo(int'(n_q) + 1));
                        end
                    end
            DONE:   begin
                        state_d = IDLE;
                        n_d     = '0;
                        j_d     = '0;
                    end
            default: state_d = IDLE;
        endcase
    end

    // The accumulator only moves while reads return, so it holds the window result throughout OUTPUT.
    always_comb begin
        busy_o      = state_q == ISSUE || state_q == DRAIN || state_q == OUTPUT;
        done_o      = state_q == DONE;
        rd_en_o     = state_q == ISSUE;
        y_valid_o   = state_q == OUTPUT;
        sig_addr_o  = j_q;
        coef_addr_o = CW'(int'(n_q) - int'(j_q));
        y_idx_o     = n_q;
        y_data_o    = DW'(acc >>> SHIFT);
    end

    fir_mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
        .clk     (clk),
        .rst     (rst),
        .a_i     (coef_data_i),
        .b_i     (sig_data_i),
        .en_i    (en_q),
        .first_i (first_q),
        .acc_o   (acc)
    );

endmodule

// File: tb/tb_fir_conv_sequencer.sv
// tb_fir_conv_sequencer: directed checks of the convolution sequencer on a small config (LEN=2, 4 samples)
// and a single-tap, single-sample config for the truncation boundary.
module tb_fir_conv_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic               start_a = 1'b0, ready_a = 1'b1;
    logic               busy_a, done_a, rd_en_a, valid_a;
    logic [1:0]         coef_addr_a, sig_addr_a;
    logic [2:0]         idx_a;
    logic signed [15:0] coef_a, sig_a, y_a;
    logic signed [15:0] ha [4];
    logic signed [15:0] xa [4];
    logic signed [15:0] exp_y [8];

    logic               start_b = 1'b0;
    logic               busy_b, done_b, rd_en_b, valid_b;
    logic [0:0]         coef_addr_b, sig_addr_b, idx_b;
    logic signed [15:0] coef_b, sig_b, y_b;
    logic signed [15:0] hb [2];
    logic signed [15:0] xb [2];

    fir_conv_sequencer #(.LEN(2), .SIGNAL_LENGTH_1(3)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .rd_en_o(rd_en_a), .coef_addr_o(coef_addr_a), .sig_addr_o(sig_addr_a),
        .coef_data_i(coef_a), .sig_data_i(sig_a), .y_data_o(y_a), .y_idx_o(idx_a),
        .y_valid_o(valid_a), .y_ready_i(ready_a)
    );

    fir_conv_sequencer #(.LEN(0), .SIGNAL_LENGTH_1(0)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .rd_en_o(rd_en_b), .coef_addr_o(coef_addr_b), .sig_addr_o(sig_addr_b),
        .coef_data_i(coef_b), .sig_data_i(sig_b), .y_data_o(y_b), .y_idx_o(idx_b),
        .y_valid_o(valid_b), .y_ready_i(1'b1)
    );

    always @(posedge clk) begin
        if (rd_en_a) begin
            coef_a <= ha[coef_addr_a];
            sig_a  <= xa[sig_addr_a];
        end
        if (rd_en_b) begin
            coef_b <= hb[coef_addr_b];
            sig_b  <= xb[sig_addr_b];
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_rd_en"}, rd_en_a, 0);
        chk({tag, "_coef_addr"}, coef_addr_a, 0);
        chk({tag, "_sig_addr"}, sig_addr_a, 0);
        chk({tag, "_y_valid"}, valid_a, 0);
        chk({tag, "_y_data"}, y_a, 0);
        chk({tag, "_y_idx"}, idx_a, 0);
    endtask

    // One run on dut_a from the current negedge; cycle k is the k-th negedge after start is taken.
    task automatic run_a(input int stall_at, input int abort_n, input bit poke, input int exp_done);
        int idx = 0, done_c = 0, n0 = 0, n4 = 0, st = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("busy_after_start", busy_a, 1);
        for (int k = 1; k <= 200 && done_c == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (poke) start_a = (k == 5);
            if (abort_n >= 0 && rd_en_a && int'(idx_a) == abort_n) begin
                rst = 1'b1;
                #1;
                chk_reset_a("abort");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (rd_en_a && idx_a == 3'd0) begin
                chk("n0_sig_addr", sig_addr_a, 0);
                chk("n0_coef_addr", coef_addr_a, 0);
                n0++;
            end
            if (rd_en_a && idx_a == 3'd4) begin
                chk("n4_sig_addr", sig_addr_a, 2 + n4);
                chk("n4_coef_addr", coef_addr_a, 2 - n4);
                n4++;
            end
            if (valid_a && int'(idx_a) == stall_at && st < 5) begin
                ready_a = 1'b0;
                st++;
                chk("stall_y_valid", valid_a, 1);
                chk("stall_y_data", y_a, exp_y[stall_at]);
                chk("stall_y_idx", idx_a, stall_at);
                chk("stall_rd_en", rd_en_a, 0);
            end else if (valid_a) begin
                ready_a = 1'b1;
                if (idx == 0) chk("first_valid_cycle", k, 3);
                chk("y_data", y_a, exp_y[idx]);
                chk("y_idx", idx_a, idx);
                idx++;
            end
            if (done_a) begin
                done_c = k;
                chk("done_cycle", k, exp_done);
            end
        end
        chk("outputs_seen", idx, 6);
        chk("n0_terms", n0, 1);
        chk("n4_terms", n4, 2);
        chk("done_seen", done_c != 0, 1);
        @(negedge clk);
        chk("done_pulse_end", done_a, 0);
        chk("idle_not_busy", busy_a, 0);
    endtask

    initial begin
        int done_c;
        ha = '{16384, 0, 0, 0};
        xa = '{100, -200, 300, 400};
        exp_y = '{100, -200, 300, 400, 0, 0, 0, 0};
        hb = '{-16384, 0};
        xb = '{-32768, 0};

        repeat (2) @(negedge clk);
        chk_reset_a("reset");
        chk("reset_b_y_data", y_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // Identity filter, then the same run with a stray start while busy.
        run_a(-1, -1, 1'b0, 25);
        run_a(-1, -1, 1'b1, 25);

        ha = '{16384, 8192, -16384, 0};
        xa = '{4, 8, -12, 2};
        exp_y = '{4, 10, -12, -12, 13, -2, 0, 0};
        run_a(-1, -1, 1'b0, 25);

        // Backpressure at n=2 on the identity filter: five extra cycles.
        ha = '{16384, 0, 0, 0};
        xa = '{100, -200, 300, 400};
        exp_y = '{100, -200, 300, 400, 0, 0, 0, 0};
        run_a(2, -1, 1'b0, 30);

        // Abort during n=3 issue, then a clean rerun.
        ha = '{16384, 8192, -16384, 0};
        xa = '{4, 8, -12, 2};
        exp_y = '{4, 10, -12, -12, 13, -2, 0, 0};
        run_a(-1, 3, 1'b0, 0);
        run_a(-1, -1, 1'b0, 25);

        // Single term -16384 * -32768 = 2^29 wraps to -32768 after the shift.
        done_c = 0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 1; k <= 20 && done_c == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (valid_b) begin
                chk("b_valid_cycle", k, 3);
                chk("b_y_data_wrap", y_b, -32768);
                chk("b_y_idx", idx_b, 0);
            end
            if (done_b) begin
                done_c = k;
                chk("b_done_cycle", k, 4);
            end
        end
        chk("b_done_seen", done_c != 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_conv_sequencer.md
Name: fir_conv_sequencer

Overview:
Controller that computes a full linear convolution y = h * x with one shared 16x16 signed MAC, one product per cycle, instead of a fully parallel datapath.
Reads filter coefficients and signal samples from external synchronous RAMs with 1-cycle read latency.
Produces one Q14-scaled output per accumulation window on a valid/ready stream.
Sits between the coefficient/signal buffers and the result collector; software-visible control is start/busy/done.

Parameters:
LEN, 19, number of taps minus 1 (taps = LEN+1)
SIGNAL_LENGTH_1, 2400, number of signal samples minus 1
DW, 16, sample/coefficient/output width (signed)
ACC_W, 40, accumulator width (signed)
SHIFT, 14, right shift applied to the accumulator on output (Q14)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
start  in  1  begin convolution; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse when the last output handshakes
rd_en  out  1  read strobe to both RAMs
coef_addr  out  $clog2(LEN+1)  coefficient RAM address
sig_addr  out  $clog2(SIGNAL_LENGTH_1+1)  signal RAM address
coef_data  in  DW  coefficient read data, valid 1 cycle after rd_en
sig_data  in  DW  signal read data, valid 1 cycle after rd_en
y_data  out  DW  output sample
y_idx  out  $clog2(LEN+SIGNAL_LENGTH_1+1)  output index n
y_valid  out  1  output valid
y_ready  in  1  downstream ready

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, coef_addr=0, sig_addr=0, y_valid=0, y_data=0, y_idx=0, acc=0, state=IDLE. Reset asserted mid-operation aborts immediately. No output or done is issued for the aborted run.
- TOTAL = LEN+SIGNAL_LENGTH_1+1 outputs, n = 0..TOTAL-1.
- For output n, j runs from jlo = max(0, n-LEN) to jhi = min(n, SIGNAL_LENGTH_1), ascending, one term per cycle. For each j: sig_addr = j, coef_addr = n-j.
- States:
  - IDLE: on start=1, go to ISSUE with n=0, j=jlo(0).
  - ISSUE: rd_en=1, one (j, n-j) pair per cycle. After issuing jhi, go to DRAIN.
  - DRAIN: rd_en=0. Absorbs the last read return, then go to OUTPUT.
  - OUTPUT: y_valid=1. y_data and y_idx are held stable until y_ready=1. On handshake: if n=TOTAL-1, go to DONE; else n++ and go to ISSUE.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Accumulate (cycle after each rd_en):
  - First term of each window: acc = sext(coef_data*sig_data).
  - Other terms: acc = acc + product.
  - A 1-cycle-delayed "first" flag marks the first term; there is no separate clear cycle.
- Output arithmetic: y_data = (acc >>> SHIFT)[DW-1:0], arithmetic shift then truncation. No saturation or rounding.
- Timing: per window, m(n) = jhi-jlo+1 issue cycles, 1 drain cycle, then ≥1 output cycle. With y_ready tied high, each window takes m(n)+2 cycles.
  - Start accepted at edge 0 → ISSUE cycle 1 → first y_valid in cycle m(0)+2 = 3.
- start while busy is ignored. start held high through DONE starts a new run from the IDLE cycle that follows.
- y_valid is never asserted outside OUTPUT. Data is never dropped under backpressure.

Decomposition:
- Package fir_pkg:
  - state enum (IDLE, ISSUE, DRAIN, OUTPUT, DONE)
  - localparams TOTAL, ADDR widths, Q-format SHIFT
- Sub-module fir_mac_unit: registered signed multiply-accumulate.
  - Inputs: a, b, en, first.
  - Output: acc.
  - Reusable by a later pipelined variant.
- Sequencer FSM, address generation and the output register live in fir_conv_sequencer.

Test Plan:
- Identity filter. LEN=2, SIGNAL_LENGTH_1=3, h={16384,0,0}, x={100,-200,300,400}, y_ready=1.
  - Required: y={100,-200,300,400,0,0} with y_idx 0..5.
  - Required: first y_valid in cycle 3 after start.
  - Required: done 24 cycles after start (total 12 terms + 2 per window) + 1.
- Address order, same config. n=4 issues (sig_addr, coef_addr) = (2,2),(3,1). n=0 issues (0,0) only.
- General convolution. h={16384,8192,-16384}, x={4,8,-12,2}.
  - Required: y={4,10,-12,-12,13,-2}.
- Truncation boundary. h0=-16384, x0=-32768, LEN=0, SIGNAL_LENGTH_1=0.
  - acc = 2^29, so y_data = 0x8000 (-32768).
  - Confirms wrap, not saturation.
- Backpressure. y_ready held low 5 cycles at n=2.
  - Required: y_valid, y_data and y_idx stable throughout.
  - Required: no rd_en during the stall.
  - Required: outputs after the stall are unchanged from the identity test.
- Control boundaries.
  - start pulsed while busy: no effect on the sequence.
  - rst asserted during ISSUE of n=3: all outputs return to reset values asynchronously.
  - Following start: produces the full correct sequence from n=0.
